// File: rtl/note_smoother.sv
// Serial per-slot amplitude smoother: exponential attack toward new peaks,
// multiplicative decay for lost peaks, publishing a coherent 12-slot frame.
module note_smoother #(
  parameter int N            = 16,
  parameter int SLOTS        = 12,
  parameter int ATTACK_SHIFT = 2,
  parameter int DECAY_SHIFT  = 3,
  parameter int MIN_AMP      = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N:0]   inNotes  [SLOTS],
  output logic [2*N:0]   outNotes [SLOTS],
  output logic           finished,
  output logic           busy
);

  // Note packing: {position[N], amplitude[N], valid}
  localparam int CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROC   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N:0]    snap_q [SLOTS];
  logic [2*N:0]    snap_d [SLOTS];
  logic [N-1:0]    wamp_q [SLOTS];
  logic [N-1:0]    wamp_d [SLOTS];
  logic [N-1:0]    wpos_q [SLOTS];
  logic [N-1:0]    wpos_d [SLOTS];
  logic [2*N:0]    out_q  [SLOTS];
  logic [2*N:0]    out_d  [SLOTS];
  logic            finished_q, finished_d;
  logic            busy_q, busy_d;

  logic [2*N:0]    cur_note_s;
  logic [N-1:0]    in_pos_s;
  logic [N-1:0]    in_amp_s;
  logic            in_vld_s;
  logic [N-1:0]    cur_amp_s;
  logic signed [N:0] diff_s;
  logic [N-1:0]    step_s;
  logic [N-1:0]    att_amp_s;
  logic [N-1:0]    dec_raw_s;
  logic [N-1:0]    dec_amp_s;

  // Datapath for the slot selected by the counter
  always_comb begin
    cur_note_s = snap_q[cnt_q];
    in_pos_s   = cur_note_s[2*N:N+1];
    in_amp_s   = cur_note_s[N:1];
    in_vld_s   = cur_note_s[0];
    cur_amp_s  = wamp_q[cnt_q];
    diff_s     = $signed({1'b0, in_amp_s}) - $signed({1'b0, cur_amp_s});
    // Attack result stays between old and new amplitude, so an N-bit wrap-add is exact
    step_s     = N'(diff_s >>> ATTACK_SHIFT);
    att_amp_s  = cur_amp_s + step_s;
    dec_raw_s  = cur_amp_s - (cur_amp_s >> DECAY_SHIFT);
    if (dec_raw_s < N'(MIN_AMP)) begin
      dec_amp_s = {N{1'b0}};
    end else begin
      dec_amp_s = dec_raw_s;
    end
  end

  // Next-state logic for the frame sequencer and all working state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    wamp_d     = wamp_q;
    wpos_d     = wpos_q;
    out_d      = out_q;
    finished_d = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = inNotes;
          cnt_d   = {CW{1'b0}};
          state_d = S_PROC;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_PROC: begin
        if (in_vld_s) begin
          wamp_d[cnt_q] = att_amp_s;
          wpos_d[cnt_q] = in_pos_s;
        end else begin
          wamp_d[cnt_q] = dec_amp_s;
        end
        if (cnt_q == CW'(SLOTS - 1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_COMMIT;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_COMMIT: begin
        for (int k = 0; k < SLOTS; k++) begin
          out_d[k] = {wpos_q[k], wamp_q[k], (wamp_q[k] >= N'(MIN_AMP))};
        end
        finished_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      snap_q     <= '{default: '0};
      wamp_q     <= '{default: '0};
      wpos_q     <= '{default: '0};
      out_q      <= '{default: '0};
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      wamp_q     <= wamp_d;
      wpos_q     <= wpos_d;
      out_q      <= out_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
    end
  end

  assign outNotes = out_q;
  assign finished = finished_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_note_smoother.sv
// Randomized self-checking bench for note_smoother against a frame-level
// arithmetic model of the attack/decay rules and handshake timing.
module tb_note_smoother;
  localparam int N     = 16;
  localparam int SLOTS = 12;
  localparam int W     = 2 * N + 1;
  localparam int POS_A = 8880;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in_notes  [SLOTS];
  logic [W-1:0] out_notes [SLOTS];
  logic         finished;
  logic         busy;

  int checks = 0;
  int errors = 0;

  int           m_amp [SLOTS];
  int           m_pos [SLOTS];
  logic [W-1:0] exp_out [SLOTS];
  logic [W-1:0] exp_new [SLOTS];
  int           st_amp [SLOTS];
  int           st_pos [SLOTS];
  bit           st_vld [SLOTS];

  always #5 clk = ~clk;

  note_smoother dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inNotes  (in_notes),
    .outNotes (out_notes),
    .finished (finished),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    for (int k = 0; k < SLOTS; k++) check($sformatf("%s[%0d]", tag, k), 64'(out_notes[k]), 64'(exp_out[k]));
  endtask

  // Frame-level model: floor division for attack, integer divide for decay
  function automatic void model_frame();
    int d, step;
    for (int k = 0; k < SLOTS; k++) begin
      if (st_vld[k]) begin
        d    = st_amp[k] - m_amp[k];
        step = (d >= 0) ? d / 4 : -((-d + 3) / 4);
        m_amp[k] = m_amp[k] + step;
        m_pos[k] = st_pos[k];
      end else begin
        m_amp[k] = m_amp[k] - m_amp[k] / 8;
        if (m_amp[k] < 16) m_amp[k] = 0;
      end
      exp_new[k] = {16'(m_pos[k]), 16'(m_amp[k]), (m_amp[k] >= 16)};
    end
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < SLOTS; k++) begin
      st_vld[k] = 1'b0;
      st_amp[k] = int'($urandom_range(0, 65535));
      st_pos[k] = int'($urandom_range(0, 65535));
    end
  endtask

  task automatic apply_stim();
    for (int k = 0; k < SLOTS; k++) in_notes[k] = {16'(st_pos[k]), 16'(st_amp[k]), st_vld[k]};
  endtask

  // Start sampled at the next edge E0; returns just after the commit edge E13
  task automatic do_frame(input int inject);
    apply_stim();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_frame();
    for (int k = 0; k < SLOTS; k++) in_notes[k] = W'({$urandom(), $urandom()});
    check("busy_e0", 64'(busy), 64'd1);
    check("fin_e0", 64'(finished), 64'd0);
    for (int e = 1; e <= 13; e++) begin
      start = (e == inject);
      @(posedge clk); #1;
      start = 1'b0;
      if (e < 13) begin
        check($sformatf("fin_e%0d", e), 64'(finished), 64'd0);
        check($sformatf("busy_e%0d", e), 64'(busy), 64'd1);
        if (e == 6 || e == 12) check_outs("hold");
      end else begin
        check("fin_commit", 64'(finished), 64'd1);
        check("busy_commit", 64'(busy), 64'd0);
        exp_out = exp_new;
        check_outs("commit");
      end
    end
    if (inject == 13) begin
      @(posedge clk); #1;
      check("busy_ign13", 64'(busy), 64'd0);
      check("fin_ign13", 64'(finished), 64'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_fin", 64'(finished), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end
    check_outs("idle_out");
  endtask

  task automatic slot_chk(input string tag, input int k, input int amp, input int vld);
    check({tag, "_amp"}, 64'(out_notes[k][N:1]), 64'(amp));
    check({tag, "_vld"}, 64'(out_notes[k][0]), 64'(vld));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    for (int k = 0; k < SLOTS; k++) begin
      m_amp[k] = 0; m_pos[k] = 0; exp_out[k] = '0;
    end
    clear_stim();
    apply_stim();
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    check("rst_fin", 64'(finished), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check_outs("rst_out");
    idle(1);

    // Attack ramp, weak note, decrease and negative rounding
    clear_stim();
    st_vld[0] = 1'b1; st_amp[0] = 10000; st_pos[0] = POS_A;
    st_vld[1] = 1'b1; st_amp[1] = 40;
    st_vld[2] = 1'b1; st_amp[2] = 16000;
    st_vld[3] = 1'b1; st_amp[3] = 8004;
    do_frame(0);
    slot_chk("att1", 0, 2500, 1);
    check("att1_pos", 64'(out_notes[0][2*N:N+1]), 64'(POS_A));
    slot_chk("weak1", 1, 10, 0);
    slot_chk("pre4000", 2, 4000, 1);
    slot_chk("pre2001", 3, 2001, 1);
    for (int k = 4; k < SLOTS; k++) check($sformatf("other_vld[%0d]", k), 64'(out_notes[k][0]), 64'd0);
    idle(2);

    st_amp[2] = 2000; st_amp[3] = 0;
    do_frame(5);
    slot_chk("att2", 0, 4375, 1);
    slot_chk("weak2", 1, 17, 1);
    slot_chk("dec3500", 2, 3500, 1);
    slot_chk("rnd1500", 3, 1500, 1);

    for (int k = 1; k < SLOTS; k++) st_vld[k] = 1'b0;
    do_frame(0);
    slot_chk("att3", 0, 5781, 1);
    slot_chk("kill17", 1, 0, 0);

    st_vld[0] = 1'b0; st_pos[0] = 123;
    do_frame(13);
    slot_chk("decay", 0, 5059, 1);
    check("decay_pos", 64'(out_notes[0][2*N:N+1]), 64'(POS_A));
    idle(2);

    // Reset during a frame: no finished, everything cleared
    clear_stim();
    st_vld[0] = 1'b1; st_amp[0] = 10000; st_pos[0] = POS_A;
    apply_stim();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      m_amp[k] = 0; m_pos[k] = 0; exp_out[k] = '0;
    end
    check("mrst_fin", 64'(finished), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check_outs("mrst_out");
    idle(15);
    do_frame(0);
    slot_chk("post_rst", 0, 2500, 1);
    idle(1);

    // Randomized frames with random ignored starts and back-to-back chaining
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < SLOTS; k++) begin
        st_vld[k] = ($urandom_range(0, 9) < 7);
        st_amp[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 65535));
        st_pos[k] = int'($urandom_range(0, 65535));
      end
      case ($urandom_range(0, 3))
        0:       do_frame(0);
        1:       do_frame(5);
        2:       do_frame(13);
        default: do_frame(int'($urandom_range(1, 12)));
      endcase
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
